// File: rtl/fact_pkg.sv
// Shared definitions for the factorial controller: state encoding and the
// default operand limit. The bench imports this package as well.
package fact_pkg;

   // State encoding
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] INIT = 2'd1;
   localparam logic [1:0] LOOP = 2'd2;
   localparam logic [1:0] CAP  = 2'd3;

   // Largest n whose factorial fits in an 8-bit result (5! = 120)
   localparam int MAX_N_DEFAULT = 5;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_INIT = INIT,
      ST_LOOP = LOOP,
      ST_CAP  = CAP
   } state_t;

endpackage : fact_pkg

// File: rtl/fact_ctrl.sv
// Control unit for the factorial datapath. It accepts a request and
// range-checks the operand. It then sequences the datapath's counter and
// register controls, captures the product and pulses done. Operands above
// MAX_N finish at once with err set, so no truncated product is reported.
module fact_ctrl
   import fact_pkg::*;
#(
   parameter int SIZE  = 8,
   parameter int MAX_N = MAX_N_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [SIZE-1:0] n_in,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [SIZE-1:0] result,
   output logic [SIZE-1:0] dp_n,
   output logic            cnt_load,
   output logic            cnt_en,
   output logic            reg_sel,
   output logic            reg_load,
   input  logic            proceed,
   input  logic [SIZE-1:0] dp_result
);

   localparam logic [SIZE-1:0] MAX_N_V = SIZE'(MAX_N);

   state_t          r_state;
   logic            r_busy;
   logic            r_done;
   logic            r_err;
   logic [SIZE-1:0] r_result;
   logic [SIZE-1:0] r_n;

   logic            w_in_range;

   assign w_in_range = (n_in <= MAX_N_V);

   // FSM plus operand/result registers; done is a one-cycle pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_result <= '0;
         r_n      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_n      <= n_in;
                  r_err    <= 1'b0;
                  r_result <= '0;
                  if (!w_in_range) begin
                     // Reject without touching the datapath
                     r_err  <= 1'b1;
                     r_done <= 1'b1;
                  end else begin
                     r_state <= ST_INIT;
                     r_busy  <= 1'b1;
                  end
               end
            end
            ST_INIT: begin
               r_state <= ST_LOOP;
            end
            ST_LOOP: begin
               // The cycle where proceed drops still multiplies by cnt == n
               if (!proceed) begin
                  r_state <= ST_CAP;
               end
            end
            ST_CAP: begin
               r_result <= dp_result;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Datapath controls are decoded directly from the current state
   assign cnt_load = (r_state == ST_INIT);
   assign reg_sel  = (r_state == ST_INIT);
   assign reg_load = (r_state == ST_INIT) || (r_state == ST_LOOP);
   assign cnt_en   = (r_state == ST_LOOP) && proceed;

   assign busy   = r_busy;
   assign done   = r_done;
   assign err    = r_err;
   assign result = r_result;
   assign dp_n   = r_n;

endmodule : fact_ctrl
